alu_sequencer: RTL and testbench

Multicycle initiator for the 32-bit combinational ALU. It takes a MIPS opcode/funct plus operand values and decodes them into the ALU's 6-bit control codes. It drives the ALU's `ctrl`/`a`/`b` inputs and registers its `r`/`r2`/`z` outputs. Variable and large shift amounts are built from repeated fixed 8/2/1-bit ALU shift passes. The block sits between the instruction decode stage and the ALU, and owns the HI/LO registers.

---
 rtl/alu_seq_pkg.sv | 102 ++++++++++
 rtl/alu_seq_decode.sv | 65 ++++++
 rtl/alu_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants, enums and shift-step helpers for the ALU sequencer.
// ALU_SEQ_MULT_EN (see alu_sequencer.sv) does not change anything in this package.
package alu_seq_pkg;

  localparam logic [5:0] ALU_AND   = 6'h00;
  localparam logic [5:0] ALU_OR    = 6'h01;
  localparam logic [5:0] ALU_ADD   = 6'h02;
  localparam logic [5:0] ALU_ADDU  = 6'h03;
  localparam logic [5:0] ALU_XOR   = 6'h04;
  localparam logic [5:0] ALU_NOR   = 6'h05;
  localparam logic [5:0] ALU_SUB   = 6'h06;
  localparam logic [5:0] ALU_SLT   = 6'h07;
  localparam logic [5:0] ALU_SLTU  = 6'h08;
  localparam logic [5:0] ALU_LUI   = 6'h09;
  localparam logic [5:0] ALU_SLL1  = 6'h0A;
  localparam logic [5:0] ALU_SLL2  = 6'h0B;
  localparam logic [5:0] ALU_SLL8  = 6'h0C;
  localparam logic [5:0] ALU_SRL1  = 6'h0D;
  localparam logic [5:0] ALU_SRL2  = 6'h0E;
  localparam logic [5:0] ALU_SRL8  = 6'h0F;
  localparam logic [5:0] ALU_SRA1  = 6'h10;
  localparam logic [5:0] ALU_SRA2  = 6'h11;
  localparam logic [5:0] ALU_SRA8  = 6'h12;
  localparam logic [5:0] ALU_MULTU = 6'h13;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_DONE = 2'd2} state_e;
  typedef enum logic [1:0] {SH_SLL = 2'd0, SH_SRL = 2'd1, SH_SRA = 2'd2} shift_e;

  typedef struct packed {
    logic [5:0] ctrl;
    logic       is_shift;
    shift_e     kind;
    logic       amt_src;   // 1: amount from a[4:0], 0: from shamt
    logic       is_mult;
    logic       is_mf;
    logic       mf_hi;
    logic       illegal;
  } dec_t;

  // Largest fixed ALU shift step not exceeding n.
  function automatic logic [4:0] step_size(input logic [4:0] n);
    if (n >= 5'd8) begin
      return 5'd8;
    end else if (n >= 5'd2) begin
      return 5'd2;
    end else if (n != 5'd0) begin
      return 5'd1;
    end else begin
      return 5'd0;
    end
  endfunction

  // ALU ctrl code for the step chosen by step_size(n) and the given shift kind.
  function automatic logic [5:0] step_ctrl(input shift_e kind, input logic [4:0] n);
    logic [5:0] base;
    logic [5:0] offs;
    case (kind)
      SH_SLL:  base = ALU_SLL1;
      SH_SRL:  base = ALU_SRL1;
      SH_SRA:  base = ALU_SRA1;
      default: base = ALU_SLL1;
    endcase
    if (n >= 5'd8) begin
      offs = 6'd2;
    end else if (n >= 5'd2) begin
      offs = 6'd1;
    end else begin
      offs = 6'd0;
    end
    return base + offs;
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode/funct decoder for the ALU sequencer.
// multu/mfhi/mflo decode as legal only when ALU_SEQ_MULT_EN is defined.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  // Translate the instruction fields into ALU control and sequencing hints.
  always_comb begin
    dec         = '0;
    dec.kind    = SH_SLL;
    if (opcode == OP_RTYPE) begin
      case (funct)
        F_AND:  dec.ctrl = ALU_AND;
        F_OR:   dec.ctrl = ALU_OR;
        F_ADD:  dec.ctrl = ALU_ADD;
        F_ADDU: dec.ctrl = ALU_ADDU;
        F_XOR:  dec.ctrl = ALU_XOR;
        F_SUB, F_SUBU: dec.ctrl = ALU_SUB;
        F_SLT:  dec.ctrl = ALU_SLT;
        F_SLTU: dec.ctrl = ALU_SLTU;
        F_SLL:  begin dec.is_shift = 1'b1; dec.kind = SH_SLL; end
        F_SRL:  begin dec.is_shift = 1'b1; dec.kind = SH_SRL; end
        F_SRA:  begin dec.is_shift = 1'b1; dec.kind = SH_SRA; end
        F_SLLV: begin dec.is_shift = 1'b1; dec.kind = SH_SLL; dec.amt_src = 1'b1; end
        F_SRLV: begin dec.is_shift = 1'b1; dec.kind = SH_SRL; dec.amt_src = 1'b1; end
        F_SRAV: begin dec.is_shift = 1'b1; dec.kind = SH_SRA; dec.amt_src = 1'b1; end
        F_MULTU: begin
`ifdef ALU_SEQ_MULT_EN
          dec.ctrl    = ALU_MULTU;
          dec.is_mult = 1'b1;
`else
          dec.illegal = 1'b1;
`endif
        end
        F_MFHI, F_MFLO: begin
`ifdef ALU_SEQ_MULT_EN
          dec.ctrl  = ALU_ADDU;
          dec.is_mf = 1'b1;
          dec.mf_hi = (funct == F_MFHI);
`else
          dec.illegal = 1'b1;
`endif
        end
        default: dec.illegal = 1'b1;
      endcase
    end else begin
      case (opcode)
        OP_ADDI:  dec.ctrl = ALU_ADD;
        OP_ADDIU: dec.ctrl = ALU_ADDU;
        OP_SLTI:  dec.ctrl = ALU_SLT;
        OP_SLTIU: dec.ctrl = ALU_SLTU;
        OP_ANDI:  dec.ctrl = ALU_AND;
        OP_ORI:   dec.ctrl = ALU_OR;
        OP_XORI:  dec.ctrl = ALU_XOR;
        OP_LUI:   dec.ctrl = ALU_LUI;
        default:  dec.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multicycle initiator for the 32-bit ALU: decode, shift stepping, HI/LO ownership.
// Define ALU_SEQ_MULT_EN to include multu/mfhi/mflo and the HI/LO registers.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] result,
  output logic        zero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [5:0]  alu_ctrl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_r,
  input  logic [31:0] alu_r2,
  input  logic        alu_z
);

  dec_t        dec_s;
  logic [4:0]  amt_s;

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic [5:0]  alu_ctrl_q, alu_ctrl_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [4:0]  rem_q, rem_d;
  shift_e      kind_q, kind_d;
  logic        is_shift_q, is_shift_d;
  logic        is_mult_q, is_mult_d;
`ifdef ALU_SEQ_MULT_EN
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
`endif

  alu_seq_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .dec    (dec_s)
  );

  assign amt_s = dec_s.amt_src ? a[4:0] : shamt;

  // Next-state, ALU drive and capture logic; alu_b doubles as the shift working value.
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    err_d      = err_q;
    result_d   = result_q;
    zero_d     = zero_q;
    alu_ctrl_d = alu_ctrl_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    rem_d      = rem_q;
    kind_d     = kind_q;
    is_shift_d = is_shift_q;
    is_mult_d  = is_mult_q;
`ifdef ALU_SEQ_MULT_EN
    hi_d       = hi_q;
    lo_d       = lo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          kind_d     = dec_s.kind;
          is_shift_d = dec_s.is_shift;
          is_mult_d  = dec_s.is_mult;
          rem_d      = 5'd0;
          alu_ctrl_d = ALU_AND;
          alu_a_d    = 32'd0;
          alu_b_d    = 32'd0;
          err_d      = dec_s.illegal;
          if (dec_s.illegal) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = 32'd0;
            zero_d   = 1'b1;
          end else if (dec_s.is_shift) begin
            state_d = ST_EXEC;
            alu_b_d = b;
            if (amt_s != 5'd0) begin
              alu_ctrl_d = step_ctrl(dec_s.kind, amt_s);
              rem_d      = amt_s - step_size(amt_s);
            end else begin
              alu_ctrl_d = ALU_ADDU;
            end
          end else if (dec_s.is_mf) begin
            state_d    = ST_EXEC;
            alu_ctrl_d = ALU_ADDU;
            alu_b_d    = dec_s.mf_hi ? hi : lo;
          end else begin
            state_d    = ST_EXEC;
            alu_ctrl_d = dec_s.ctrl;
            alu_a_d    = a;
            alu_b_d    = b;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (is_shift_q && (rem_q != 5'd0)) begin
          alu_ctrl_d = step_ctrl(kind_q, rem_q);
          alu_a_d    = 32'd0;
          alu_b_d    = alu_r;
          rem_d      = rem_q - step_size(rem_q);
        end else begin
          state_d    = ST_DONE;
          done_d     = 1'b1;
          result_d   = alu_r;
          zero_d     = alu_z;
          alu_ctrl_d = ALU_AND;
          alu_a_d    = 32'd0;
          alu_b_d    = 32'd0;
`ifdef ALU_SEQ_MULT_EN
          if (is_mult_q) begin
            hi_d = alu_r2;
            lo_d = alu_r;
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      result_q   <= 32'd0;
      zero_q     <= 1'b0;
      alu_ctrl_q <= 6'd0;
      alu_a_q    <= 32'd0;
      alu_b_q    <= 32'd0;
      rem_q      <= 5'd0;
      kind_q     <= SH_SLL;
      is_shift_q <= 1'b0;
      is_mult_q  <= 1'b0;
`ifdef ALU_SEQ_MULT_EN
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      alu_ctrl_q <= alu_ctrl_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      rem_q      <= rem_d;
      kind_q     <= kind_d;
      is_shift_q <= is_shift_d;
      is_mult_q  <= is_mult_d;
`ifdef ALU_SEQ_MULT_EN
      hi_q       <= hi_d;
      lo_q       <= lo_d;
`endif
    end
  end

`ifdef ALU_SEQ_MULT_EN
  assign hi = hi_q;
  assign lo = lo_q;
`else
  logic unused_mult_s;
  assign unused_mult_s = ^{alu_r2, is_mult_q};
  assign hi = 32'd0;
  assign lo = 32'd0;
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign alu_ctrl = alu_ctrl_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Table-driven bench for alu_sequencer with a behavioural ALU on the alu_* ports.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] result;
  logic        zero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [5:0]  alu_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_r;
  logic [31:0] alu_r2;
  logic        alu_z;

  int total_cnt = 0;
  int bad_cnt   = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .funct(funct),
    .shamt(shamt), .a(a), .b(b), .busy(busy), .done(done), .err(err),
    .result(result), .zero(zero), .hi(hi), .lo(lo), .alu_ctrl(alu_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r), .alu_r2(alu_r2), .alu_z(alu_z)
  );

  // Reference 32-bit ALU: shifts act on alu_b, multu yields {r2, r}.
  logic [63:0] prod;
  always_comb begin
    prod   = {32'd0, alu_a} * {32'd0, alu_b};
    alu_r2 = 32'd0;
    case (alu_ctrl)
      6'h00: alu_r = alu_a & alu_b;
      6'h01: alu_r = alu_a | alu_b;
      6'h02: alu_r = alu_a + alu_b;
      6'h03: alu_r = alu_a + alu_b;
      6'h04: alu_r = alu_a ^ alu_b;
      6'h05: alu_r = ~(alu_a | alu_b);
      6'h06: alu_r = alu_a - alu_b;
      6'h07: alu_r = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      6'h08: alu_r = (alu_a < alu_b) ? 32'd1 : 32'd0;
      6'h09: alu_r = {alu_b[15:0], 16'h0000};
      6'h0A: alu_r = alu_b << 1;
      6'h0B: alu_r = alu_b << 2;
      6'h0C: alu_r = alu_b << 8;
      6'h0D: alu_r = alu_b >> 1;
      6'h0E: alu_r = alu_b >> 2;
      6'h0F: alu_r = alu_b >> 8;
      6'h10: alu_r = $signed(alu_b) >>> 1;
      6'h11: alu_r = $signed(alu_b) >>> 2;
      6'h12: alu_r = $signed(alu_b) >>> 8;
      6'h13: begin alu_r = prod[31:0]; alu_r2 = prod[63:32]; end
      default: alu_r = 32'd0;
    endcase
    alu_z = (alu_r == 32'd0);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Issue one op from an IDLE cycle, wait for done, check it; returns in the next IDLE cycle.
  task automatic run_op(input string nm, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] sh, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] er, input logic ez, input logic eer, input int elat);
    int lat;
    opcode = op; funct = fn; shamt = sh; a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    chk({nm, ".busy"}, {63'd0, busy}, 64'd1);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, ".latency"}, lat, elat);
    chk({nm, ".result"}, {32'd0, result}, {32'd0, er});
    chk({nm, ".zero"}, {63'd0, zero}, {63'd0, ez});
    chk({nm, ".err"}, {63'd0, err}, {63'd0, eer});
    @(negedge clk);
    chk({nm, ".idle"}, {62'd0, done, busy}, 64'd0);
    chk({nm, ".alu_idle"}, {alu_ctrl, alu_b[25:0], 32'd0} | {32'd0, alu_a}, 64'd0);
  endtask

  typedef struct {
    string       nm;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] er;
    logic        ez;
    logic        eer;
    int          elat;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int dcnt;
    int lat;
    vecs[0]  = '{"add",    6'h00, 6'h20, 5'd0,  32'd5,        32'hFFFFFFFB, 32'h00000000, 1'b1, 1'b0, 2};
    vecs[1]  = '{"srav13", 6'h00, 6'h07, 5'd0,  32'd13,       32'h80000000, 32'hFFFC0000, 1'b0, 1'b0, 5};
    vecs[2]  = '{"sll0",   6'h00, 6'h00, 5'd0,  32'd0,        32'h00001234, 32'h00001234, 1'b0, 1'b0, 2};
    vecs[3]  = '{"sll31",  6'h00, 6'h00, 5'd31, 32'd0,        32'h00000001, 32'h80000000, 1'b0, 1'b0, 8};
    vecs[4]  = '{"badfn",  6'h00, 6'h3F, 5'd0,  32'd7,        32'd9,        32'h00000000, 1'b1, 1'b1, 1};
    vecs[5]  = '{"sub",    6'h00, 6'h22, 5'd0,  32'd10,       32'd3,        32'h00000007, 1'b0, 1'b0, 2};
    vecs[6]  = '{"slt",    6'h00, 6'h2A, 5'd0,  32'hFFFFFFFF, 32'd1,        32'h00000001, 1'b0, 1'b0, 2};
    vecs[7]  = '{"sltu",   6'h00, 6'h2B, 5'd0,  32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b1, 1'b0, 2};
    vecs[8]  = '{"srl4",   6'h00, 6'h02, 5'd4,  32'd0,        32'hF0000000, 32'h0F000000, 1'b0, 1'b0, 3};
    vecs[9]  = '{"sra9",   6'h00, 6'h03, 5'd9,  32'd0,        32'h80000000, 32'hFFC00000, 1'b0, 1'b0, 3};
    vecs[10] = '{"sllv3",  6'h00, 6'h04, 5'd0,  32'h00000023, 32'h00000001, 32'h00000008, 1'b0, 1'b0, 3};
    vecs[11] = '{"lui",    6'h0F, 6'h00, 5'd0,  32'd0,        32'h0000ABCD, 32'hABCD0000, 1'b0, 1'b0, 2};
    vecs[12] = '{"andi",   6'h0C, 6'h00, 5'd0,  32'hFF00FF00, 32'h00000F0F, 32'h00000F00, 1'b0, 1'b0, 2};
    vecs[13] = '{"xori",   6'h0E, 6'h00, 5'd0,  32'h0000FFFF, 32'h0000FFFF, 32'h00000000, 1'b1, 1'b0, 2};
    vecs[14] = '{"badop",  6'h23, 6'h00, 5'd0,  32'd1,        32'd2,        32'h00000000, 1'b1, 1'b1, 1};

    rst = 1'b1; start = 1'b0; opcode = 6'd0; funct = 6'd0; shamt = 5'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset.flags", {61'd0, busy, done, err}, 64'd0);
    chk("reset.result", {31'd0, zero, result}, 64'd0);
    chk("reset.hilo", {hi, lo}, 64'd0);
    chk("reset.alu", {26'd0, alu_ctrl, alu_a} | {32'd0, alu_b}, 64'd0);

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].nm, vecs[i].op, vecs[i].fn, vecs[i].sh, vecs[i].va, vecs[i].vb,
             vecs[i].er, vecs[i].ez, vecs[i].eer, vecs[i].elat);
    end

`ifdef ALU_SEQ_MULT_EN
    run_op("multu", 6'h00, 6'h19, 5'd0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b0, 1'b0, 2);
    chk("multu.hi", {32'd0, hi}, 64'd1);
    chk("multu.lo", {32'd0, lo}, 64'hFFFFFFFE);
    run_op("mfhi", 6'h00, 6'h10, 5'd0, 32'd0, 32'd0, 32'h00000001, 1'b0, 1'b0, 2);
    run_op("mflo", 6'h00, 6'h12, 5'd0, 32'd0, 32'd0, 32'hFFFFFFFE, 1'b0, 1'b0, 2);
`else
    run_op("multu", 6'h00, 6'h19, 5'd0, 32'hFFFFFFFF, 32'd2, 32'h00000000, 1'b1, 1'b1, 1);
    chk("multu.hilo", {hi, lo}, 64'd0);
    run_op("mfhi", 6'h00, 6'h10, 5'd0, 32'd0, 32'd0, 32'h00000000, 1'b1, 1'b1, 1);
`endif

    // srlv by 16 (steps 8,8) with a stray start pulse in its first EXEC cycle.
    opcode = 6'h00; funct = 6'h06; shamt = 5'd0; a = 32'd16; b = 32'h80000000; start = 1'b1;
    @(negedge clk);
    funct = 6'h20; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    lat = 2;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("ignore.latency", lat, 3);
    chk("ignore.result", {32'd0, result}, 64'h00008000);
    dcnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("ignore.no_second_done", dcnt, 0);
    chk("ignore.busy", {63'd0, busy}, 64'd0);

    // Reset in the second EXEC cycle of a 31-bit shift.
    opcode = 6'h00; funct = 6'h00; shamt = 5'd31; a = 32'd0; b = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.busy_done", {62'd0, busy, done}, 64'd0);
    chk("abort.result", {32'd0, result}, 64'd0);
    chk("abort.hilo", {hi, lo}, 64'd0);
    chk("abort.alu_ctrl", {58'd0, alu_ctrl}, 64'd0);
    dcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("abort.quiet", dcnt, 0);

    run_op("post_abort_add", 6'h00, 6'h21, 5'd0, 32'd40, 32'd2, 32'd42, 1'b0, 1'b0, 2);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
